// File: rtl/axi_master_rw_if.sv
// AXI4 read/write channel bundle between the burst master and the interconnect.
interface axi_master_rw_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      ARVALID;
  logic [LEN_WIDTH-1:0]      ARLEN;
  logic [2:0]                ARSIZE;
  logic [1:0]                ARBURST;
  logic                      RVALID;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic                      RLAST;
  logic [1:0]                RRESP;
  logic                      RREADY;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      AWVALID;
  logic [LEN_WIDTH-1:0]      AWLEN;
  logic [2:0]                AWSIZE;
  logic [1:0]                AWBURST;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      BVALID;
  logic [1:0]                BRESP;
  logic                      BREADY;

  modport master (
    input  ARREADY, RVALID, RDATA, RLAST, RRESP, AWREADY, WREADY, BVALID, BRESP,
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
           AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
           WDATA, WSTRB, WLAST, WVALID, BREADY
  );

  modport slave (
    output ARREADY, RVALID, RDATA, RLAST, RRESP, AWREADY, WREADY, BVALID, BRESP,
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
           AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
           WDATA, WSTRB, WLAST, WVALID, BREADY
  );
endinterface

// File: rtl/axi_master_rw.sv
// AXI4 INCR burst master: independent read and write engines, one burst per start
// command, with user valid/ready data streams and a per-burst error flag.
module axi_master_rw #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] target_read_addr,
  input  logic [LEN_WIDTH-1:0]  target_read_burst_len,
  output logic                  done_read,
  output logic                  read_error,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  start_write,
  input  logic [ADDR_WIDTH-1:0] target_write_addr,
  input  logic [LEN_WIDTH-1:0]  target_write_burst_len,
  output logic                  done_write,
  output logic                  write_error,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  axi_master_rw_if.master       axi
);
  localparam logic [2:0]           AXSIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1'b1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} w_state_e;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  rd_len_q, rd_len_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic                  rd_err_q, rd_err_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_read_q, done_read_d;
  logic                  read_error_q, read_error_d;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0]  wr_len_q, wr_len_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  done_write_q, done_write_d;
  logic                  write_error_q, write_error_d;

  logic r_hs_s, w_hs_s, w_last_s, unused_resp_s;

  assign r_hs_s        = (r_state_q == R_DATA) & axi.RVALID & rd_ready;
  assign w_hs_s        = (w_state_q == W_DATA) & wr_valid & axi.WREADY;
  assign w_last_s      = (wr_cnt_q == wr_len_q);
  assign unused_resp_s = axi.RRESP[0] ^ axi.BRESP[0];

  // Read engine next-state and registered-output computation
  always_comb begin
    r_state_d    = r_state_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_cnt_d     = rd_cnt_q;
    rd_err_d     = rd_err_q;
    arvalid_d    = 1'b0;
    done_read_d  = 1'b0;
    read_error_d = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (start_read) begin
          rd_addr_d = target_read_addr;
          rd_len_d  = target_read_burst_len;
          rd_cnt_d  = '0;
          rd_err_d  = 1'b0;
          arvalid_d = 1'b1;
          r_state_d = R_ADDR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        if (axi.ARREADY) begin
          r_state_d = R_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          rd_cnt_d = rd_cnt_q + LEN_ONE;
          // A short burst (RLAST before len beats) is flagged as an error too
          if (axi.RLAST) begin
            read_error_d = rd_err_q | axi.RRESP[1] | (rd_cnt_q != rd_len_q);
            rd_err_d     = read_error_d;
            done_read_d  = 1'b1;
            r_state_d    = R_DONE;
          end else begin
            rd_err_d = rd_err_q | axi.RRESP[1];
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= R_IDLE;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_cnt_q     <= '0;
      rd_err_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      done_read_q  <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_err_q     <= rd_err_d;
      arvalid_q    <= arvalid_d;
      done_read_q  <= done_read_d;
      read_error_q <= read_error_d;
    end
  end

  // Write engine next-state and registered-output computation
  always_comb begin
    w_state_d     = w_state_q;
    wr_addr_d     = wr_addr_q;
    wr_len_d      = wr_len_q;
    wr_cnt_d      = wr_cnt_q;
    awvalid_d     = 1'b0;
    bready_d      = 1'b0;
    done_write_d  = 1'b0;
    write_error_d = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (start_write) begin
          wr_addr_d = target_write_addr;
          wr_len_d  = target_write_burst_len;
          wr_cnt_d  = '0;
          awvalid_d = 1'b1;
          w_state_d = W_ADDR;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_ADDR: begin
        if (axi.AWREADY) begin
          w_state_d = W_DATA;
        end else begin
          awvalid_d = 1'b1;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          wr_cnt_d = wr_cnt_q + LEN_ONE;
          if (w_last_s) begin
            bready_d  = 1'b1;
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      W_RESP: begin
        if (axi.BVALID) begin
          write_error_d = axi.BRESP[1];
          done_write_d  = 1'b1;
          w_state_d     = W_DONE;
        end else begin
          bready_d = 1'b1;
        end
      end
      W_DONE:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q     <= W_IDLE;
      wr_addr_q     <= '0;
      wr_len_q      <= '0;
      wr_cnt_q      <= '0;
      awvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      done_write_q  <= 1'b0;
      write_error_q <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      wr_addr_q     <= wr_addr_d;
      wr_len_q      <= wr_len_d;
      wr_cnt_q      <= wr_cnt_d;
      awvalid_q     <= awvalid_d;
      bready_q      <= bready_d;
      done_write_q  <= done_write_d;
      write_error_q <= write_error_d;
    end
  end

  assign axi.ARADDR  = rd_addr_q;
  assign axi.ARLEN   = rd_len_q;
  assign axi.ARSIZE  = AXSIZE;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = arvalid_q;
  // Data streams are pass-through, gated so nothing moves outside the DATA state
  assign axi.RREADY  = (r_state_q == R_DATA) & rd_ready;
  assign rd_valid    = (r_state_q == R_DATA) & axi.RVALID;
  assign rd_data     = axi.RDATA;
  assign done_read   = done_read_q;
  assign read_error  = read_error_q;

  assign axi.AWADDR  = wr_addr_q;
  assign axi.AWLEN   = wr_len_q;
  assign axi.AWSIZE  = AXSIZE;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid_q;
  assign axi.WVALID  = (w_state_q == W_DATA) & wr_valid;
  assign wr_ready    = (w_state_q == W_DATA) & axi.WREADY;
  assign axi.WDATA   = wr_data;
  assign axi.WSTRB   = {(DATA_WIDTH/8){1'b1}};
  assign axi.WLAST   = (w_state_q == W_DATA) & w_last_s;
  assign axi.BREADY  = bready_q;
  assign done_write  = done_write_q;
  assign write_error = write_error_q;
endmodule
